// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display: one shared
// hex decoder time-multiplexed across the anodes, with dead time and zero blanking.
module seg_scan_ctrl #(
  parameter int DIV  = 100000,
  parameter int DEAD = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        lzb,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [3:0]  an
);
  // state    | meaning
  // ST_BLANK | dead time at slot start, or scan disabled: all pins dark
  // ST_SHOW  | current digit driven with its decoded nibble and dp
  // ST_SUPP  | leading-zero digit with lzb set: dark like ST_BLANK
  localparam logic [1:0] ST_BLANK = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_SUPP  = 2'd2;

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          start_q, start_d;
  logic [15:0]   pend_q, pend_d;
  logic          pvld_q, pvld_d;
  logic [15:0]   disp_q, disp_d;
  logic [6:0]    seg_q, seg_d;
  logic          dpn_q, dpn_d;
  logic [3:0]    an_q, an_d;

  logic          slot_end;
  logic          frame_start;
  logic [1:0]    st;
  logic [3:0]    nib;
  logic [15:0]   upper;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end    = (cnt_q == CW'(DIV - 1));
  // start_q marks the first slot after reset or after en was low
  assign frame_start = en && (start_q || (slot_end && (idx_q == 2'd3)));
  assign nib         = disp_q[{idx_q, 2'b00} +: 4];
  assign upper       = disp_q >> {idx_q, 2'b00};

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    start_d = start_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    disp_d  = disp_q;
    if (frame_start && pvld_q) begin
      disp_d = pend_q;
      pvld_d = 1'b0;
    end
    if (en) begin
      start_d = 1'b0;
      if (slot_end) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d   = '0;
      idx_d   = 2'd0;
      start_d = 1'b1;
    end
    // a load coinciding with a frame start lands in pending for the next frame
    if (load) begin
      pend_d = value;
      pvld_d = 1'b1;
    end
  end

  always_comb begin
    st = ST_SHOW;
    if (!en || (cnt_q < CW'(DEAD))) begin
      st = ST_BLANK;
    end else if (lzb && (idx_q != 2'd0) && (upper == 16'h0000)) begin
      st = ST_SUPP;
    end
  end

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dpn_d = 1'b1;
    if (st == ST_SHOW) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex7(nib);
      dpn_d = ~dp[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      start_q <= 1'b1;
      pend_q  <= 16'h0000;
      pvld_q  <= 1'b0;
      disp_q  <= 16'h0000;
      seg_q   <= 7'h7F;
      dpn_q   <= 1'b1;
      an_q    <= 4'b1111;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      dpn_q   <= dpn_d;
      an_q    <= an_d;
    end
  end

  assign seg  = seg_q;
  assign dp_n = dpn_q;
  assign an   = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed display scenarios plus a randomized run
// against a position-based reference model of the scanned display.
module tb_seg_scan_ctrl;
  localparam int DIV   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp = 4'b0000;
  logic        lzb = 1'b0;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model: m_pos = cycles into the current frame, m_fresh = next enabled edge starts a frame
  int          m_pos;
  bit          m_fresh;
  logic [15:0] m_pend, m_disp;
  bit          m_pvld;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_dpn;

  seg_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .dp(dp), .lzb(lzb), .seg(seg), .dp_n(dp_n), .an(an)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic m_reset();
    m_pos = 0; m_fresh = 1; m_pend = 16'h0; m_pvld = 0; m_disp = 16'h0;
  endtask

  task automatic tick();
    int c, d;
    @(posedge clk);
    e_an = 4'b1111; e_seg = 7'h7F; e_dpn = 1'b1;
    if (en) begin
      c = m_pos % DIV;
      d = m_pos / DIV;
      if (c >= DEAD && !(lzb && d > 0 && (m_disp >> (4 * d)) == 16'h0)) begin
        e_an  = ~(4'b0001 << d);
        e_seg = lut[(m_disp >> (4 * d)) & 16'hF];
        e_dpn = ~dp[d];
      end
    end
    if (en && (m_fresh || m_pos == FRAME - 1) && m_pvld) begin
      m_disp = m_pend; m_pvld = 0;
    end
    if (load) begin m_pend = value; m_pvld = 1; end
    if (en) begin m_pos = (m_pos + 1) % FRAME; m_fresh = 0; end
    else begin m_pos = 0; m_fresh = 1; end
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] xa; logic [6:0] xs;
    rst_n = 1'b0; en = 1'b1; load = 1'b0; lzb = 1'b0; dp = 4'b0000; value = 16'h0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp_n !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hold: an=%b seg=%h dp_n=%b, want 1111 7f 1", an, seg, dp_n);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      xa = ((k % 8) < 2) ? 4'b1111 : ((k < 8) ? 4'b1110 : 4'b1101);
      xs = ((k % 8) < 2) ? 7'h7F : 7'h40;
      vectors++;
      if (an !== xa || seg !== xs || dp_n !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_release k=%0d: an=%b seg=%h dp_n=%b, want %b %h 1", k, an, seg, dp_n, xa, xs);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] at [4]; logic [6:0] st [4]; logic dt [4];
    at = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    st = '{7'h0E, 7'h08, 7'h24, 7'h79};
    dt = '{1'b1, 1'b1, 1'b0, 1'b1};
    dp = 4'b0100;
    do_load(16'h12AF);
    for (int i = 0; i < FRAME && m_pos != 0; i++) tick();
    for (int k = 0; k < FRAME; k++) begin
      tick();
      vectors++;
      if ((k % DIV) < DEAD) begin
        if (an !== 4'b1111 || seg !== 7'h7F || dp_n !== 1'b1) begin
          miscompares++;
          $display("FAIL scan_dead k=%0d: an=%b seg=%h dp_n=%b, want dark", k, an, seg, dp_n);
        end
      end else if (an !== at[k / DIV] || seg !== st[k / DIV] || dp_n !== dt[k / DIV]) begin
        miscompares++;
        $display("FAIL scan_show k=%0d: an=%b seg=%h dp_n=%b, want %b %h %b",
                 k, an, seg, dp_n, at[k / DIV], st[k / DIV], dt[k / DIV]);
      end
      vectors++;
      if ($countones(~an) > 1) begin
        miscompares++;
        $display("FAIL scan_onehot k=%0d: an=%b, want at most one low", k, an);
      end
    end
  endtask

  task automatic test_tearfree();
    int p;
    logic [3:0] at [4]; logic [6:0] st [4];
    at = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    st = '{7'h0E, 7'h08, 7'h24, 7'h79};
    for (int i = 0; i < FRAME && m_pos != DIV + DEAD + 1; i++) tick();
    dp = 4'b0000;
    do_load(16'h0000);
    for (int i = 0; i < FRAME && m_pos != 0; i++) begin
      p = m_pos;
      tick();
      if ((p % DIV) >= DEAD) begin
        vectors++;
        if (an !== at[p / DIV] || seg !== st[p / DIV]) begin
          miscompares++;
          $display("FAIL tear_old p=%0d: an=%b seg=%h, want %b %h", p, an, seg, at[p / DIV], st[p / DIV]);
        end
      end
    end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if ((k % DIV) >= DEAD) begin
        vectors++;
        if (an !== at[k / DIV] || seg !== 7'h40 || dp_n !== 1'b1) begin
          miscompares++;
          $display("FAIL tear_new k=%0d: an=%b seg=%h dp_n=%b, want %b 40 1", k, an, seg, dp_n, at[k / DIV]);
        end
      end
    end
  endtask

  task automatic test_lzb();
    logic [3:0] at [4]; logic [6:0] st [4];
    at = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    st = '{7'h40, 7'h30, 7'h7F, 7'h7F};
    lzb = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        at[1] = 4'b1111; st[1] = 7'h7F;
      end
      do_load((pass == 0) ? 16'h0030 : 16'h0000);
      for (int i = 0; i < FRAME && m_pos != 0; i++) tick();
      for (int k = 0; k < FRAME; k++) begin
        tick();
        if ((k % DIV) >= DEAD) begin
          vectors++;
          if (an !== at[k / DIV] || seg !== st[k / DIV] || dp_n !== 1'b1) begin
            miscompares++;
            $display("FAIL lzb pass=%0d k=%0d: an=%b seg=%h dp_n=%b, want %b %h 1",
                     pass, k, an, seg, dp_n, at[k / DIV], st[k / DIV]);
          end
        end
      end
    end
    lzb = 1'b0;
  endtask

  task automatic test_enable();
    for (int i = 0; i < 2 * FRAME && m_pos != 2 * DIV + DEAD + 1; i++) tick();
    vectors++;
    if (an !== 4'b1011) begin
      miscompares++;
      $display("FAIL enable_pre: an=%b, want 1011", an);
    end
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (an !== 4'b1111 || seg !== 7'h7F || dp_n !== 1'b1) begin
        miscompares++;
        $display("FAIL enable_off k=%0d: an=%b seg=%h dp_n=%b, want dark", k, an, seg, dp_n);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (an !== ((k < 2) ? 4'b1111 : 4'b1110)) begin
        miscompares++;
        $display("FAIL enable_on k=%0d: an=%b, want %b", k, an, (k < 2) ? 4'b1111 : 4'b1110);
      end
    end
  endtask

  task automatic test_async_reset();
    do_load(16'h5555);
    for (int i = 0; i < 2 * FRAME && m_pos != 0; i++) tick();
    repeat (4) tick();
    vectors++;
    if (an !== 4'b1110 || seg !== 7'h12) begin
      miscompares++;
      $display("FAIL areset_pre: an=%b seg=%h, want 1110 12", an, seg);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp_n !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_dark: an=%b seg=%h dp_n=%b, want dark", an, seg, dp_n);
    end
    m_reset();
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (an !== ((k < 2 || k > 7) ? 4'b1111 : 4'b1110) || seg !== ((k < 2 || k > 7) ? 7'h7F : 7'h40)) begin
        miscompares++;
        $display("FAIL areset_restart k=%0d: an=%b seg=%h", k, an, seg);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) lzb = ~lzb;
      if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
      load = ($urandom_range(0, 11) == 0);
      v = 16'($urandom);
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 1) == 0) v[4 * j +: 4] = 4'h0;
      value = v;
      tick();
      vectors++;
      if (an !== e_an || seg !== e_seg || dp_n !== e_dpn) begin
        miscompares++;
        $display("FAIL random n=%0d: an=%b seg=%h dp_n=%b, want %b %h %b", n, an, seg, dp_n, e_an, e_seg, e_dpn);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tearfree();
    test_lzb();
    test_enable();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
